// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply core: sequencer FSM encoding and default widths.
package matmul_pkg;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/index_counter.sv
// Loop index register with synchronous clear, load and increment (clear > load > inc).
module index_counter
  import matmul_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          inc,
  output logic [DW-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      value <= '0;
    else if (clear) value <= '0;
    else if (load)  value <= load_val;
    else if (inc)   value <= value + DW'(1);
  end

endmodule

// File: rtl/matmul_index_sequencer.sv
// i/j/k loop controller for C = A x B: multiplier-free row-major addressing and MAC strobes.
// Outputs are decoded from registered state; stall only gates the strobes combinationally.
module matmul_index_sequencer
  import matmul_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dim_m,
  input  logic [DW-1:0] dim_n,
  input  logic [DW-1:0] dim_p,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_c,
  input  logic          stall,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          wr_en,
  output logic [DW-1:0] idx_i,
  output logic [DW-1:0] idx_j,
  output logic [DW-1:0] idx_k,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [DW-1:0] m_q, n_q, p_q;
  logic [AW-1:0] base_b_q;
  logic [AW-1:0] row_a, col_b, ptr_a, ptr_b, ptr_c;
  logic          run_go, wr_go, last_i, last_j, last_k, zero_dim;
  logic          i_clr, i_inc, j_clr, j_inc, k_clr, k_inc;

  assign run_go   = (state == ST_RUN) && !stall;
  assign wr_go    = (state == ST_WRITE) && !stall;
  assign last_i   = (idx_i == m_q - DW'(1));
  assign last_j   = (idx_j == p_q - DW'(1));
  assign last_k   = (idx_k == n_q - DW'(1));
  assign zero_dim = (m_q == '0) || (n_q == '0) || (p_q == '0);

  index_counter #(.DW(DW)) u_cnt_i (
    .clk(clk), .reset(reset), .clear(i_clr), .load(1'b0), .load_val('0), .inc(i_inc), .value(idx_i)
  );
  index_counter #(.DW(DW)) u_cnt_j (
    .clk(clk), .reset(reset), .clear(j_clr), .load(1'b0), .load_val('0), .inc(j_inc), .value(idx_j)
  );
  index_counter #(.DW(DW)) u_cnt_k (
    .clk(clk), .reset(reset), .clear(k_clr), .load(1'b0), .load_val('0), .inc(k_inc), .value(idx_k)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_clr = 1'b0;
    i_inc = 1'b0;
    j_clr = 1'b0;
    j_inc = 1'b0;
    k_clr = 1'b0;
    k_inc = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        i_clr     = 1'b1;
        j_clr     = 1'b1;
        k_clr     = 1'b1;
        state_nxt = zero_dim ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (run_go) begin
          if (last_k) state_nxt = ST_WRITE;
          else        k_inc     = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wr_go) begin
          k_clr = 1'b1;
          if (!last_j) begin
            j_inc = 1'b1;
          end else begin
            j_clr = 1'b1;
            i_inc = !last_i;
          end
          state_nxt = (last_i && last_j) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // row_a/col_b hold the k=0 addresses of the current row of A and column of B,
  // so the inner-loop pointers can be rewound without a multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      base_b_q <= '0;
      row_a    <= '0;
      col_b    <= '0;
      ptr_a    <= '0;
      ptr_b    <= '0;
      ptr_c    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_q      <= dim_m;
            n_q      <= dim_n;
            p_q      <= dim_p;
            base_b_q <= base_b;
            row_a    <= base_a;
            ptr_a    <= base_a;
            col_b    <= base_b;
            ptr_b    <= base_b;
            ptr_c    <= base_c;
          end
        end
        ST_RUN: begin
          if (run_go && !last_k) begin
            ptr_a <= ptr_a + AW'(1);
            ptr_b <= ptr_b + AW'(p_q);
          end
        end
        ST_WRITE: begin
          if (wr_go) begin
            ptr_c <= ptr_c + AW'(1);
            if (!last_j) begin
              col_b <= col_b + AW'(1);
              ptr_b <= col_b + AW'(1);
              ptr_a <= row_a;
            end else begin
              col_b <= base_b_q;
              ptr_b <= base_b_q;
              if (!last_i) begin
                row_a <= row_a + AW'(n_q);
                ptr_a <= row_a + AW'(n_q);
              end else begin
                ptr_a <= row_a;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_a    = ptr_a;
  assign addr_b    = ptr_b;
  assign addr_c    = ptr_c;
  assign mac_en    = run_go;
  assign mac_clear = run_go && (idx_k == '0);
  assign wr_en     = wr_go;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: doc/matmul_index_sequencer.md
# matmul_index_sequencer

Loop controller for a single matrix-multiply core computing C = A × B. It owns the i/j/k loop indices, generates row-major word addresses for the A, B and C memories, and drives the MAC datapath's clear, accumulate and write-back strobes. It sits between the core's command interface (start/done) and the 16-bit index/address registers and MAC unit it sequences.

## Interface
- `AW`, default 16: address width; all address arithmetic is modulo 2^AW.
- `DW`, default 16: dimension/index width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces IDLE and all registers to 0.
- `start` in 1: begin operation; sampled only in IDLE.
- `dim_m` in DW: rows of A (M).
- `dim_n` in DW: cols of A = rows of B (N).
- `dim_p` in DW: cols of B (P).
- `base_a`, `base_b`, `base_c` in AW each: base word addresses of A, B, C.
- `stall` in 1: freezes RUN/WRITE progress (memory not ready).
- `addr_a`, `addr_b` out AW: operand read addresses.
- `addr_c` out AW: result write address.
- `mac_en` out 1: datapath multiplies the current A/B operands this cycle.
- `mac_clear` out 1: with `mac_en`, load the product instead of accumulating.
- `wr_en` out 1: write the accumulator to `addr_c`.
- `idx_i`, `idx_j`, `idx_k` out DW: current loop indices.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Dimensions and bases are latched on the `start` edge; input changes while busy have no effect. A `start` while busy is ignored.
- FSM states: IDLE, LOAD, RUN, WRITE, DONE.
- IDLE→LOAD on `start`. In LOAD, if any of M, N or P is 0, go to DONE with no `mac_en` or `wr_en`. Otherwise go to RUN with i=j=k=0.
- RUN, not stalled: `mac_en`=1, `mac_clear`=(k==0). If k==N-1, go to WRITE; otherwise k++.
- WRITE, not stalled: `wr_en`=1, `addr_c`=base_c+i·P+j. Then k=0.
  - If j<P-1: j++.
  - Else j=0; if i<M-1, i++.
  - If i==M-1 and j==P-1, go to DONE; otherwise go to RUN.
- DONE: `done`=1 for one cycle, then IDLE.
- `stall`=1 in RUN or WRITE forces `mac_en`, `mac_clear` and `wr_en` to 0 and holds state, indices and addresses. `stall` is ignored in IDLE, LOAD and DONE.
- Addresses: `addr_a`=base_a+i·N+k and `addr_b`=base_b+k·P+j. Both are built without multipliers, from running pointers:
  - The A pointer steps by +1 per k.
  - The B pointer steps by +P per k.
  - The row-of-A base steps by +N per i.
  - The C pointer steps by +1 per write.
- Pointer overflow wraps modulo 2^AW silently.
- The index counters are DW bits wide. They never exceed dim−1, so they do not wrap.

## Timing
- Reset values, all outputs: 0; state IDLE.
- Reset asserted mid-operation aborts immediately: no `done` pulse, and outputs are 0 asynchronously.
- All outputs are Moore (decoded from registered state and pointers), except that `stall` gates `mac_en`, `mac_clear` and `wr_en` combinationally.
- `start` sampled at edge t0 gives LOAD in cycle 1 and first RUN in cycle 2.
- Unstalled duration from the `start` edge to the `done` pulse: M·P·(N+1)+2 cycles.
- Each stalled cycle adds exactly one cycle.
- The datapath accumulator registers each `mac_en`, so the value driven during WRITE includes the last product.
- Address outputs are valid in the same cycle as their strobe.

## Structure
- Shared package `matmul_pkg`:
  - FSM state encodings.
  - Default AW and DW.
- Sub-module `index_counter`: DW-bit register with synchronous load, clear and increment, plus async reset. Priority: clear > load > inc. It is instantiated three times, for i, j and k.
- Pointer adders live in the top level.

## Test plan
- Reset mid-RUN → next cycle state IDLE, all outputs 0, no `done`.
  - Restart afterwards → normal completion.
- M=2, N=3, P=2, bases 0x000/0x100/0x200, no stall:
  - `done` 18 cycles after the start edge.
  - `addr_a` sequence 0,1,2,0,1,2,3,4,5,…
  - `addr_b` sequence 0x100,0x102,0x104,0x101,…
  - `wr_en` at `addr_c` 0x200–0x203 in order.
  - `mac_clear` high every third `mac_en`.
- Same run with `stall` high for 3 cycles mid-RUN and 2 cycles in WRITE:
  - `done` at 23 cycles.
  - No strobe while stalled.
  - Address trace unchanged.
- M=0 (also N=0, then P=0) → LOAD, DONE, IDLE: `done` at cycle 2, zero strobes.
- M=N=P=1, base_a=0xFFFF:
  - 1 `mac_en` with `mac_clear`, `addr_a`=0xFFFF.
  - 1 `wr_en`.
  - `done` at cycle 4.
- `start` pulsed while busy and dims changed mid-run → ignored; trace identical to the unperturbed run.
